// File: rtl/infix_to_postfix_if.sv
// Handshake/data bundle between the expression source and the converter.
// The converter takes the slave side; postEval-facing results come back out.
interface infix_to_postfix_if #(
    parameter int depth    = 10,
    parameter int newWidth = 44
);
    localparam int CW = $clog2(depth + 1);

    logic                               conv;
    logic [CW-1:0]                      infixSize;
    logic [depth-1:0][newWidth-1:0]     infix;
    logic [depth-1:0][newWidth-1:0]     postfix;
    logic [CW-1:0]                      postfixSize;
    logic                               done;
    logic                               error;

    modport master (
        output conv, infixSize, infix,
        input  postfix, postfixSize, done, error
    );

    modport slave (
        input  conv, infixSize, infix,
        output postfix, postfixSize, done, error
    );
endinterface

// File: rtl/infix_to_postfix.sv
// Sequential shunting-yard converter: infix token array to postfix array.
// One token or one operator-stack move per cycle; feeds postEval.
module infix_to_postfix #(
    parameter int depth    = 10,
    parameter int newWidth = 44
) (
    input  logic                clock,
    input  logic                reset,
    infix_to_postfix_if.slave   bus
);
    localparam int CW = $clog2(depth + 1);

    typedef logic [newWidth-1:0] tok_t;
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_POP, S_PAREN, S_FUNC, S_FLUSH, S_DONE
    } state_t;

    function automatic logic f_op(input tok_t t);
        return t[newWidth-1 -: 2] == 2'b01;
    endfunction
    function automatic logic f_is(input tok_t t, input logic [7:0] c);
        return f_op(t) && (t[7:0] == c);
    endfunction
    function automatic logic f_bin(input tok_t t);
        return f_op(t) && (t[7:0] >= 8'h2A) && (t[7:0] <= 8'h2D);
    endfunction
    // 2C/2D carry the higher precedence
    function automatic logic f_hi(input tok_t t);
        return t[3:2] == 2'b11;
    endfunction
    function automatic logic f_func(input tok_t t);
        return f_op(t) && (t[7:3] == 5'b11110) && (t[2:0] != 3'd7);
    endfunction

    state_t             r_state, w_next;
    logic               r_conv_q;
    logic [CW-1:0]      r_idx, r_out, r_sp, r_psize;
    logic               r_error;
    tok_t               r_stk [depth];
    logic [depth-1:0][newWidth-1:0] r_post;

    logic [CW-1:0]  w_size, w_sp1, w_sp2;
    tok_t           w_tok, w_top, w_emit_val;
    logic           w_rise, w_const, w_lpar, w_rpar, w_comma, w_legal;
    logic           w_yield, w_under_func, w_top_lpar;
    logic           w_start, w_push, w_pop, w_emit, w_inc, w_err, w_fin;

    assign w_rise  = bus.conv & ~r_conv_q;
    assign w_size  = (bus.infixSize > CW'(depth)) ? CW'(depth) : bus.infixSize;
    assign w_sp1   = r_sp - CW'(1);
    assign w_sp2   = r_sp - CW'(2);
    assign w_tok   = (r_idx < CW'(depth)) ? bus.infix[r_idx] : '0;
    assign w_top   = (r_sp != '0) ? r_stk[w_sp1] : '0;

    assign w_const = w_tok[newWidth-1 -: 2] == 2'b00;
    assign w_lpar  = f_is(w_tok, 8'h28);
    assign w_rpar  = f_is(w_tok, 8'h29);
    assign w_comma = f_is(w_tok, 8'h2E);
    assign w_legal = w_const | f_bin(w_tok) | f_func(w_tok)
                   | w_lpar | w_rpar | w_comma;

    assign w_top_lpar   = (r_sp != '0) && f_is(w_top, 8'h28);
    assign w_yield      = (r_sp != '0) && f_bin(w_top)
                        && (f_hi(w_top) | ~f_hi(w_tok));
    assign w_under_func = (r_sp >= CW'(2)) && f_func(r_stk[w_sp2]);

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_emit     = 1'b0;
        w_emit_val = w_top;
        w_inc      = 1'b0;
        w_err      = 1'b0;
        w_fin      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_start = 1'b1;
                    w_next  = S_READ;
                end
            end
            S_READ: begin
                if (r_idx >= w_size) begin
                    w_next = S_FLUSH;
                end else if (!w_legal) begin
                    w_err = 1'b1;
                end else if (w_const) begin
                    w_emit     = 1'b1;
                    w_emit_val = w_tok;
                    w_inc      = 1'b1;
                end else if (f_func(w_tok) || w_lpar) begin
                    w_push = 1'b1;
                    w_inc  = 1'b1;
                end else if (w_rpar || w_comma) begin
                    w_next = S_PAREN;
                end else if (w_yield) begin
                    w_next = S_POP;
                end else begin
                    w_push = 1'b1;
                    w_inc  = 1'b1;
                end
            end
            S_POP: begin
                if (w_yield) begin
                    w_emit = 1'b1;
                    w_pop  = 1'b1;
                end else begin
                    w_push = 1'b1;
                    w_inc  = 1'b1;
                    w_next = S_READ;
                end
            end
            S_PAREN: begin
                if (r_sp == '0) begin
                    w_err = 1'b1;
                end else if (w_top_lpar) begin
                    if (w_comma) begin
                        w_inc  = 1'b1;
                        w_next = S_READ;
                    end else begin
                        w_pop = 1'b1;
                        if (w_under_func) begin
                            w_next = S_FUNC;
                        end else begin
                            w_inc  = 1'b1;
                            w_next = S_READ;
                        end
                    end
                end else begin
                    w_emit = 1'b1;
                    w_pop  = 1'b1;
                end
            end
            S_FUNC: begin
                w_emit = 1'b1;
                w_pop  = 1'b1;
                w_inc  = 1'b1;
                w_next = S_READ;
            end
            S_FLUSH: begin
                if (r_sp == '0) begin
                    w_fin  = 1'b1;
                    w_next = S_DONE;
                end else if (w_top_lpar) begin
                    w_err = 1'b1;
                end else begin
                    w_emit = 1'b1;
                    w_pop  = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_push && r_sp == CW'(depth)) w_err = 1'b1;
        if (w_emit && r_out == CW'(depth)) w_err = 1'b1;
        // An error abandons the conversion without touching any state
        if (w_err) begin
            w_next = S_IDLE;
            w_push = 1'b0;
            w_pop  = 1'b0;
            w_emit = 1'b0;
            w_inc  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_conv_q <= 1'b0;
            r_idx    <= '0;
            r_out    <= '0;
            r_sp     <= '0;
            r_psize  <= '0;
            r_error  <= 1'b0;
            r_post   <= '0;
            for (int i = 0; i < depth; i++) r_stk[i] <= '0;
        end else begin
            r_state  <= w_next;
            r_conv_q <= bus.conv;
            if (w_start) begin
                r_idx   <= '0;
                r_out   <= '0;
                r_sp    <= '0;
                r_psize <= '0;
                r_error <= 1'b0;
            end
            if (w_inc) r_idx <= r_idx + CW'(1);
            if (w_emit) begin
                r_post[r_out] <= w_emit_val;
                r_out         <= r_out + CW'(1);
            end
            if (w_pop) r_sp <= w_sp1;
            if (w_push) begin
                r_stk[r_sp] <= w_tok;
                r_sp        <= r_sp + CW'(1);
            end
            if (w_fin) r_psize <= r_out;
            if (w_err) begin
                r_error <= 1'b1;
                r_psize <= '0;
            end
        end
    end

    assign bus.postfix     = r_post;
    assign bus.postfixSize = r_psize;
    assign bus.done        = (r_state == S_DONE);
    assign bus.error       = r_error;
endmodule

// File: doc/infix_to_postfix.md
Name: infix_to_postfix

Overview:
- Sequential shunting-yard converter. Takes a tokenised infix expression and writes the postfix token array plus size that postEval consumes.
- Sits directly upstream of postEval: its postfix/postfixSize outputs connect to postEval's inputs, and its done pulse triggers postEval's conv.
- Processes one token or one operator-stack move per cycle.

Parameters:
- depth, 10: maximum tokens in the infix input, the postfix output, and the internal operator stack.
- newWidth, 44: token width. [43:42] is the tag, [41:0] is the payload.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- conv  in  1  start request. Rising edge detected internally; holding it high does not retrigger.
- infixSize  in  $clog2(depth+1)  number of valid infix tokens.
- infix  in  newWidth x [depth-1:0]  infix token array. Index 0 is the leftmost token.
- postfix  out  newWidth x [depth-1:0]  postfix token array. Each entry holds the unmodified input token.
- postfixSize  out  $clog2(depth+1)  number of valid postfix entries.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag. Cleared by the next accepted conv.

Behaviour:
- Token classes:
  - Tag 2'b00: constant; copied to output.
  - Tag 2'b01: operator, with the code in [7:0].
  - Binary operators 2A/2B (precedence 1) and 2C/2D (precedence 2); all left-associative.
  - Functions F0, F1, F4, F5, F6 (unary) and F2, F3 (two-argument, prefix form e.g. pow(x,a)).
  - Grouping codes 28 '(', 29 ')', 2E ','.
  - Any other code, or tag 1x: error.
- Reset (reset low, asynchronous): state=S_IDLE; postfixSize=0; done=0; error=0; all postfix entries=0; read index, output index, operator-stack pointer=0; conv edge register=0.
- S_IDLE: done=0. On a conv rising edge: clear indices and stack pointer, error=0, go to S_READ.
- S_READ (one infix token per cycle, while index < infixSize):
  - Constant: write to postfix[out], out+1, index+1.
  - Function or '(': push, index+1.
  - Binary op: if stack top is a binary op with precedence >= incoming, go to S_POP without consuming. Otherwise push and index+1.
  - ')' or ',': go to S_PAREN without consuming.
  - index == infixSize: go to S_FLUSH.
- S_POP: pops one operator per cycle to the output while the top is a binary op with precedence >= the pending token's precedence. Then pushes the pending token, index+1, returns to S_READ.
- S_PAREN: pops one operator per cycle until the top is '('.
  - ',': leaves '(' on the stack.
  - ')': discards '(' in that cycle. If the new top is a function, emits it in the next cycle. Then index+1, back to S_READ.
- S_FLUSH: pops one operator per cycle to the output until the stack is empty, then goes to S_DONE.
- S_DONE: postfixSize=out, done=1 for exactly one cycle, go to S_IDLE.
- Error conditions, each of which sets error=1, forces done=0 and goes to S_IDLE with postfixSize=0:
  - ')' or ',' reaching an empty stack (unmatched).
  - '(' found during S_FLUSH.
  - Push with the stack full, or write with out == depth.
  - Illegal token.
- Latency: one cycle per constant, one per push, one per pop, plus one S_DONE cycle.
- Boundaries:
  - infixSize=0: postfixSize=0 and done pulses; the empty result is not an error.
  - conv edge while busy: ignored.
  - reset asserted mid-conversion: immediate return to reset values; no done pulse.
- postfix and postfixSize are stable from the done pulse until the next accepted conv.
- Arithmetic validity (operand counts) is not checked here; postEval handles that.

Test Plan:
- 3 + 4 * 2 (5 tokens), conv pulse -> postfix = 3,4,2,2C,2A; postfixSize=5; one done pulse; error=0.
- ( 3 + 4 ) * 2 -> postfix = 3,4,2A,2,2C; postfixSize=5; parentheses not emitted.
- sin ( 1 ) + 2 -> postfix = 1,F4,2,2A; F2 ( 2 , 3 ) -> postfix = 2,3,F2; postfixSize=4 and 3 respectively.
- 3 ) + 4 -> error=1, done never asserted, postfixSize=0. A following valid conv clears error and produces a correct result.
- 8 - 3 - 1 -> postfix = 8,3,2B,1,2B (left associativity). conv held high for 20 cycles -> exactly one conversion and one done.
- reset driven low during S_POP of 1*2*3*4 -> all outputs return to reset values at once. After release plus a conv, postfix = 1,2,2C,3,2C,4,2C.
